// File: rtl/mod_arith_pkg.sv
// mod_arith_pkg: shared moduli, limb geometry, normalizer state type and limb selector.
package mod_arith_pkg;
    localparam int LIMB_W = 32;
    localparam int NLIMB = 8;
    localparam logic [NLIMB*LIMB_W-1:0] MP0 =
        256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;
    localparam logic [NLIMB*LIMB_W-1:0] MP1 =
        256'hFFFFFFFF00000000FFFFFFFFFFFFFFFFBCE6FAADA7179E84F3B9CAC2FC632551;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic logic [LIMB_W-1:0] limb_sel(input logic [NLIMB*LIMB_W-1:0] v, input logic [2:0] i);
        return v[i*LIMB_W +: LIMB_W];
    endfunction
endpackage

// File: rtl/mod_arith_norm_if.sv
// mod_arith_norm_if: request/result bundle between controller and normalizer.
interface mod_arith_norm_if;
    import mod_arith_pkg::*;
    logic start;
    logic flg_mod;
    logic [NLIMB*LIMB_W-1:0] bp;
    logic [NLIMB*LIMB_W-1:0] bn;
    logic busy;
    logic done;
    logic [NLIMB*LIMB_W-1:0] rp;
    modport master (output start, flg_mod, bp, bn, input busy, done, rp);
    modport slave (input start, flg_mod, bp, bn, output busy, done, rp);
endinterface

// File: rtl/mod_norm_limb.sv
// mod_norm_limb: one limb of d = a - b - bin cascaded into e = d + m + cin.
module mod_norm_limb
    import mod_arith_pkg::*;
(
    input  logic [LIMB_W-1:0] a,
    input  logic [LIMB_W-1:0] b,
    input  logic [LIMB_W-1:0] m,
    input  logic              bin,
    input  logic              cin,
    output logic [LIMB_W-1:0] d,
    output logic [LIMB_W-1:0] e,
    output logic              bout,
    output logic              cout
);
    assign {bout, d} = {1'b0, a} - {1'b0, b} - {{LIMB_W{1'b0}}, bin};
    assign {cout, e} = {1'b0, d} + {1'b0, m} + {{LIMB_W{1'b0}}, cin};
endmodule

// File: rtl/mod_arith_norm.sv
// mod_arith_norm: word-serial (bp - bn) mod p, picking d or d + p by the final borrow.
module mod_arith_norm
    import mod_arith_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    mod_arith_norm_if.slave bus
);
    localparam int W = NLIMB*LIMB_W;
    state_t state;
    logic [2:0] cnt;
    logic b, c, bout, cout;
    logic [W-1:0] bp_r, bn_r, p_r, dreg, ereg, rp_r;
    logic [LIMB_W-1:0] d, e;
    mod_norm_limb u_limb (
        .a(limb_sel(bp_r, cnt)),
        .b(limb_sel(bn_r, cnt)),
        .m(limb_sel(p_r, cnt)),
        .bin(b),
        .cin(c),
        .d(d),
        .e(e),
        .bout(bout),
        .cout(cout)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            b <= 1'b0;
            c <= 1'b0;
            bp_r <= '0;
            bn_r <= '0;
            p_r <= '0;
            dreg <= '0;
            ereg <= '0;
            rp_r <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    bp_r <= bus.bp;
                    bn_r <= bus.bn;
                    p_r <= bus.flg_mod ? MP1 : MP0;
                    cnt <= '0;
                    b <= 1'b0;
                    c <= 1'b0;
                    state <= RUN;
                end
                RUN: begin
                    b <= bout;
                    c <= cout;
                    dreg[cnt*LIMB_W +: LIMB_W] <= d;
                    ereg[cnt*LIMB_W +: LIMB_W] <= e;
                    cnt <= cnt + 3'd1;
                    // result latched on the last limb so it is already valid while done is high
                    if (cnt == 3'd7) begin
                        rp_r <= bout ? {e, ereg[W-LIMB_W-1:0]} : {d, dreg[W-LIMB_W-1:0]};
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.busy = state != IDLE;
    assign bus.done = state == DONE;
    assign bus.rp = rp_r;
endmodule

// File: tb/tb_mod_arith_norm.sv
// tb_mod_arith_norm: directed and random checks of the normalizer against an arithmetic model.
module tb_mod_arith_norm;
    import mod_arith_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    mod_arith_norm_if ifc ();
    mod_arith_norm dut (.clk(clk), .rst_n(rst_n), .bus(ifc));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] ref_model(input logic [255:0] a, input logic [255:0] s, input logic f);
        logic [256:0] p;
        logic [256:0] r;
        p = {1'b0, f ? MP1 : MP0};
        r = (a >= s) ? {1'b0, a} - {1'b0, s} : {1'b0, a} + p - {1'b0, s};
        return r[255:0];
    endfunction

    function automatic logic [255:0] rnd_below(input logic f);
        logic [255:0] x;
        for (int i = 0; i < 8; i++) x[i*32 +: 32] = $urandom;
        return x % (f ? MP1 : MP0);
    endfunction

    task automatic do_op(input string tag, input logic [255:0] a, input logic [255:0] s,
                         input logic f, input logic [255:0] exp);
        int dk;
        dk = 0;
        @(negedge clk);
        ifc.start = 1'b1; ifc.bp = a; ifc.bn = s; ifc.flg_mod = f;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) ifc.start = 1'b0;
            check({tag, "_busy"}, 256'(ifc.busy), 256'(k <= 9));
            if (ifc.done) begin
                if (dk == 0) dk = k;
                check({tag, "_rp"}, ifc.rp, exp);
            end
        end
        check({tag, "_lat"}, 256'(dk), 256'd9);
    endtask

    initial begin
        int nd, dk;
        logic [255:0] a, s;
        logic f;
        ifc.start = 1'b0; ifc.flg_mod = 1'b0; ifc.bp = '0; ifc.bn = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 256'(ifc.busy), 256'd0);
        check("rst_done", 256'(ifc.done), 256'd0);
        check("rst_rp", ifc.rp, 256'd0);
        rst_n = 1'b1;
        @(negedge clk);
        do_op("sub_pos", 256'd5, 256'd3, 1'b0, 256'd2);
        do_op("sub_neg_p0", 256'd3, 256'd5, 1'b0,
              256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFD);
        do_op("sub_neg_p1", 256'd0, 256'd1, 1'b1,
              256'hFFFFFFFF00000000FFFFFFFFFFFFFFFFBCE6FAADA7179E84F3B9CAC2FC632550);
        do_op("equal_p1", MP1 - 256'd1, MP1 - 256'd1, 1'b1, 256'd0);
        do_op("borrow_32", 256'd1 << 32, 256'd1, 1'b0, 256'hFFFFFFFF);
        do_op("borrow_224", 256'd1 << 224, 256'd1, 1'b0, (256'd1 << 224) - 256'd1);
        // a start during RUN must be dropped entirely
        @(negedge clk);
        ifc.start = 1'b1; ifc.bp = 256'd5; ifc.bn = 256'd3; ifc.flg_mod = 1'b0;
        nd = 0; dk = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) ifc.start = 1'b0;
            if (k == 4) begin ifc.start = 1'b1; ifc.bp = 256'd100; ifc.bn = 256'd1; ifc.flg_mod = 1'b1; end
            if (k == 5) ifc.start = 1'b0;
            if (ifc.done) begin nd++; dk = k; end
        end
        check("ign_ndone", 256'(nd), 256'd1);
        check("ign_cycle", 256'(dk), 256'd9);
        check("ign_rp", ifc.rp, 256'd2);
        // reset mid-run discards the operation
        @(negedge clk);
        ifc.start = 1'b1; ifc.bp = 256'd7; ifc.bn = 256'd2; ifc.flg_mod = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) ifc.start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("arst_busy", 256'(ifc.busy), 256'd0);
        check("arst_done", 256'(ifc.done), 256'd0);
        check("arst_rp", ifc.rp, 256'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (ifc.done) nd++;
        end
        check("arst_nodone", 256'(nd), 256'd0);
        check("arst_rp_hold", ifc.rp, 256'd0);
        do_op("post_rst", 256'd7, 256'd2, 1'b0, 256'd5);
        for (int t = 0; t < 20; t++) begin
            f = 1'(t & 1);
            a = rnd_below(f);
            s = rnd_below(f);
            if (t == 3) a = s;
            do_op("rand", a, s, f, ref_model(a, s, f));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
